// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed multiply/divide for the ALU stage.
// MUL is radix-2 Booth (one bit per clock), DIV is restoring division on
// operand magnitudes followed by a sign-fix cycle. Results land on
// zhi_out/zlo_out when the FSM enters DONE and hold until the next result.
// Optional feature macro: MDU_DIV_EN (defined = divider present; undefined =
// DIV requests fault immediately and no divider logic is built).
module mul_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              busy,
  output logic              done,
  output logic              div_fault,
  output logic [DATA_W-1:0] zhi_out,
  output logic [DATA_W-1:0] zlo_out
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
`ifdef MDU_DIV_EN
  localparam logic [2:0] S_FIX  = 3'd3;
`endif
  localparam logic [2:0] S_DONE = 3'd4;

  // Control and result registers (reset by clear)
  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] zhi_q, zhi_d;
  logic [DATA_W-1:0] zlo_q, zlo_d;

  // Working registers: a_q holds the multiplicand / dividend, acc_q is the
  // Booth partial product high part or the divide remainder, lo_q is the
  // multiplier being shifted out or the quotient being shifted in.
  logic [DATA_W-1:0]        a_q, a_d;
  logic signed [DATA_W:0]   acc_q, acc_d;
  logic [DATA_W-1:0]        lo_q, lo_d;
  logic                     q1_q, q1_d;

  // Booth step: add/subtract the multiplicand by the current bit pair
  logic signed [DATA_W:0]   m_ext;
  logic signed [DATA_W:0]   bsum;

`ifdef MDU_DIV_EN
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] amag_in;
  logic [DATA_W-1:0] dmag;
  logic [DATA_W:0]   rsh;
  logic [DATA_W:0]   rdiff;
  logic [DATA_W-1:0] qfix;
  logic [DATA_W-1:0] rfix;
`endif

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign div_fault = fault_q;
  assign zhi_out   = zhi_q;
  assign zlo_out   = zlo_q;

  // Booth add/sub selection for the current multiplier bit pair
  always_comb begin
    m_ext = {a_q[DATA_W-1], a_q};
    unique case ({lo_q[0], q1_q})
      2'b01:   bsum = acc_q + m_ext;
      2'b10:   bsum = acc_q - m_ext;
      default: bsum = acc_q;
    endcase
  end

`ifdef MDU_DIV_EN
  // Restoring-divide trial subtraction and final sign correction
  always_comb begin
    amag_in = a_in[DATA_W-1] ? -a_in : a_in;
    dmag    = b_q[DATA_W-1] ? -b_q : b_q;
    rsh     = {acc_q[DATA_W-1:0], lo_q[DATA_W-1]};
    rdiff   = rsh - {1'b0, dmag};
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    qfix    = (a_q[DATA_W-1] ^ b_q[DATA_W-1]) ? -lo_q : lo_q;
    rfix    = a_q[DATA_W-1] ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
  end
`endif

  // FSM next-state, iteration datapath and result capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    zhi_d   = zhi_q;
    zlo_d   = zlo_q;
    a_d     = a_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    q1_d    = q1_q;
`ifdef MDU_DIV_EN
    b_d     = b_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          fault_d = 1'b0;
          cnt_d   = '0;
          a_d     = a_in;
          acc_d   = '0;
          q1_d    = 1'b0;
          if (op) begin
            state_d = S_DIV;
`ifdef MDU_DIV_EN
            b_d     = b_in;
            lo_d    = amag_in;
`endif
          end else begin
            state_d = S_MUL;
            lo_d    = b_in;
          end
        end
      end

      S_MUL: begin
        // Arithmetic right shift of {acc, lo, q1} after the add/sub.
        acc_d = {bsum[DATA_W], bsum[DATA_W:1]};
        lo_d  = {bsum[0], lo_q[DATA_W-1:1]};
        q1_d  = lo_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          zhi_d   = bsum[DATA_W:1];
          zlo_d   = {bsum[0], lo_q[DATA_W-1:1]};
          state_d = S_DONE;
        end
      end

      S_DIV: begin
`ifdef MDU_DIV_EN
        if ((cnt_q == '0) && (b_q == '0)) begin
          zhi_d   = a_q;
          zlo_d   = '1;
          fault_d = 1'b1;
          state_d = S_DONE;
        end else begin
          if (!rdiff[DATA_W]) begin
            acc_d = rdiff;
            lo_d  = {lo_q[DATA_W-2:0], 1'b1};
          end else begin
            acc_d = rsh;
            lo_d  = {lo_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = S_FIX;
          end
        end
`else
        zhi_d   = '0;
        zlo_d   = '0;
        fault_d = 1'b1;
        state_d = S_DONE;
`endif
      end

`ifdef MDU_DIV_EN
      S_FIX: begin
        zhi_d   = rfix;
        zlo_d   = qfix;
        state_d = S_DONE;
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and visible results, cleared asynchronously
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      zhi_q   <= '0;
      zlo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      zhi_q   <= zhi_d;
      zlo_q   <= zlo_d;
    end
  end

  // Working datapath registers; always reloaded at accept, so no reset
  always_ff @(posedge clock) begin
    a_q   <= a_d;
    acc_q <= acc_d;
    lo_q  <= lo_d;
    q1_q  <= q1_d;
`ifdef MDU_DIV_EN
    b_q   <= b_d;
`endif
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit against a
// plain-arithmetic reference model. Honours MDU_DIV_EN the same way as the RTL.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic         op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic         div_fault;
  logic [W-1:0] zhi_out;
  logic [W-1:0] zlo_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] prev_hi = '0;
  logic [W-1:0] prev_lo = '0;

  mul_div_unit #(.DATA_W(W)) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .div_fault (div_fault),
    .zhi_out   (zhi_out),
    .zlo_out   (zlo_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: result, fault flag and edges from accept to done.
  function automatic void model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo,
                                output logic f, output int lat);
    longint signed sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!o) begin
      p = sa * sb;
      hi = p[63:32]; lo = p[31:0]; f = 1'b0; lat = 32;
    end
`ifdef MDU_DIV_EN
    else if (b == '0) begin
      hi = a; lo = '1; f = 1'b1; lat = 1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      hi = r[31:0]; lo = q[31:0]; f = 1'b0; lat = 33;
    end
`else
    else begin
      hi = '0; lo = '0; f = 1'b1; lat = 1;
    end
`endif
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = 32'h8000_0000;
      2:       v = '1;
      3:       v = 32'd1;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // One full operation; poke>0 pulses a competing DIV start at edge E<poke>.
  task automatic run_op(input string tag, input logic o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int poke);
    logic [W-1:0] eh, el;
    logic         ef;
    int           lat, n;
    model(o, a, b, eh, el, ef, lat);
    @(negedge clock);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clock); #1;
    start = 1'b0; op = 1'($urandom); a_in = $urandom; b_in = $urandom;
    check($sformatf("%s/busy_at_accept", tag), busy, 1);
    check($sformatf("%s/done_at_accept", tag), done, 0);
    check($sformatf("%s/fault_at_accept", tag), div_fault, 0);
    check($sformatf("%s/z_hold", tag), {zhi_out, zlo_out}, {prev_hi, prev_lo});
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      if (poke > 0 && n == poke - 1) begin
        start = 1'b1; op = 1'b1; a_in = $urandom; b_in = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
    check($sformatf("%s/latency", tag), n, lat);
    check($sformatf("%s/z", tag), {zhi_out, zlo_out}, {eh, el});
    check($sformatf("%s/fault", tag), div_fault, ef);
    // start during DONE must be dropped
    start = 1'b1; op = 1'b0; a_in = $urandom; b_in = $urandom;
    @(posedge clock); #1;
    start = 1'b0;
    check($sformatf("%s/idle_busy", tag), busy, 0);
    check($sformatf("%s/idle_done", tag), done, 0);
    check($sformatf("%s/z_after", tag), {zhi_out, zlo_out}, {eh, el});
    prev_hi = eh;
    prev_lo = el;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
    #12;
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    check("reset/fault", div_fault, 0);
    check("reset/z", {zhi_out, zlo_out}, 64'd0);
    @(negedge clock);
    clear = 1'b0;

    run_op("mul_7_m3", 1'b0, 32'd7, -32'sd3, 0);
    run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("div_m17_5", 1'b1, -32'sd17, 32'd5, 0);
    run_op("div_100_0", 1'b1, 32'd100, 32'd0, 0);
    run_op("mul_2_3", 1'b0, 32'd2, 32'd3, 0);
    run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("div_9_3", 1'b1, 32'd9, 32'd3, 0);
    run_op("mul_9_3", 1'b0, 32'd9, 32'd3, 0);
    run_op("mul_5_5_poke", 1'b0, 32'd5, 32'd5, 10);

    // clear in the middle of a multiply
    @(negedge clock);
    start = 1'b1; op = 1'b0; a_in = 32'd5; b_in = 32'd5;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #2 clear = 1'b1;
    #1;
    check("midclr/busy", busy, 0);
    check("midclr/done", done, 0);
    check("midclr/fault", div_fault, 0);
    check("midclr/z", {zhi_out, zlo_out}, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    prev_hi = '0;
    prev_lo = '0;
    run_op("after_clear", 1'b0, 32'd5, 32'd5, 0);

    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rand%0d", i), 1'($urandom), pick(), pick(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
